// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package sram_bus_arbiter_pkg;

    localparam int DATA_ADDR_BUS_W = 32;
    localparam int DATA_BUS_W      = 32;
    localparam int SEL_W           = 4;
    localparam int TIMEOUT_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_ACC  = 2'd1,
        ST_I_ACC  = 2'd2,
        ST_I_DISC = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// External single-port memory bus shared by instruction fetch and data access.
// Handshake: the master raises m_ce_o with m_we/m_sel/m_addr/m_wdata stable and keeps them
// until the slave returns a one-cycle m_ack_i (m_rdata_i valid with it); acks while m_ce_o=0 are ignored.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m_ce_o;
    logic              m_we_o;
    logic [3:0]        m_sel_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [DATA_W-1:0] m_rdata_i;
    logic              m_ack_i;

    modport master (
        output m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o,
        input  m_rdata_i, m_ack_i
    );

    modport slave (
        input  m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o,
        output m_rdata_i, m_ack_i
    );
endinterface

// File: rtl/sram_bus_timeout_cnt.sv
// Cycle counter for bus accesses: cleared by clr_i, advanced by en_i, flags TIMEOUT-1 reached.
module sram_bus_timeout_cnt
    import sram_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == TIMEOUT_CNT_W'(TIMEOUT - 1));

    // Saturates at the expiry value so a late abort can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sram_bus_arbiter.sv
// Serialises IF and MEM accesses onto one memory port (data first), buffers read data and
// holds the pipeline stalled until every pending request of the current cycle is satisfied.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DATA_ADDR_BUS_W,
    parameter int DATA_W  = DATA_BUS_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              d_ce_i,
    input  logic              d_we_i,
    input  logic [SEL_W-1:0]  d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    input  logic              flush_i,
    input  logic              pipe_stall_i,
    output logic              stallreq_o,
    output logic              bus_err_o,
    output logic [1:0]        dbg_state_o,
    sram_bus_arbiter_if.master bus
);
    arb_state_e        state_q, state_d;
    logic              m_we_q, m_we_d;
    logic [SEL_W-1:0]  m_sel_q, m_sel_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] if_buf_q, if_buf_d;
    logic [DATA_W-1:0] d_buf_q, d_buf_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              d_kill_q, d_kill_d;

    logic busy, ack, abort, done, consume, drop, expired;

    sram_bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst),
        .clr_i     (!busy),
        .en_i      (busy),
        .expired_o (expired)
    );

    assign busy    = (state_q != ST_IDLE);
    assign ack     = busy && bus.m_ack_i;
    assign abort   = busy && expired && !bus.m_ack_i;
    assign done    = ack || abort;
    // Gated by reset so the stall request is low while the block is held in reset.
    assign stallreq_o = rst && ((if_ce_i && !if_valid_q) || (d_ce_i && !d_valid_q));
    assign consume = !stallreq_o && !pipe_stall_i;
    // A flush or an advancing pipeline orphans the access in flight.
    assign drop    = flush_i || consume;

    assign bus.m_ce_o    = busy;
    assign bus.m_we_o    = m_we_q;
    assign bus.m_sel_o   = m_sel_q;
    assign bus.m_addr_o  = m_addr_q;
    assign bus.m_wdata_o = m_wdata_q;
    assign if_data_o     = if_buf_q;
    assign d_rdata_o     = d_buf_q;
    assign bus_err_o     = abort;
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d    = state_q;
        m_we_d     = m_we_q;
        m_sel_d    = m_sel_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_buf_d   = if_buf_q;
        d_buf_d    = d_buf_q;
        if_valid_d = if_valid_q;
        d_valid_d  = d_valid_q;
        d_kill_d   = d_kill_q;

        if (drop) begin
            if_valid_d = 1'b0;
            d_valid_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                d_kill_d = 1'b0;
                if (d_ce_i && !d_valid_q) begin
                    state_d   = ST_D_ACC;
                    m_we_d    = d_we_i;
                    m_sel_d   = d_sel_i;
                    m_addr_d  = d_addr_i;
                    m_wdata_d = d_wdata_i;
                end else if (if_ce_i && !if_valid_q) begin
                    state_d   = ST_I_ACC;
                    m_we_d    = 1'b0;
                    m_sel_d   = '1;
                    m_addr_d  = if_addr_i;
                    m_wdata_d = '0;
                end
            end
            // Stores are never torn: a flush only suppresses the result, not the access.
            ST_D_ACC: begin
                if (drop) d_kill_d = 1'b1;
                if (done) begin
                    state_d = ST_IDLE;
                    if (!d_kill_q && !drop) begin
                        d_buf_d   = (ack && !m_we_q) ? bus.m_rdata_i : '0;
                        d_valid_d = 1'b1;
                    end
                end
            end
            ST_I_ACC: begin
                if (done) begin
                    state_d = ST_IDLE;
                    if (!drop) begin
                        if_buf_d   = ack ? bus.m_rdata_i : '0;
                        if_valid_d = 1'b1;
                    end
                end else if (drop) begin
                    state_d = ST_I_DISC;
                end
            end
            ST_I_DISC: begin
                if (done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            m_we_q     <= 1'b0;
            m_sel_q    <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_buf_q   <= '0;
            d_buf_q    <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            d_kill_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_we_q     <= m_we_d;
            m_sel_q    <= m_sel_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_buf_q   <= if_buf_d;
            d_buf_q    <= d_buf_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            d_kill_q   <= d_kill_d;
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: fetch, load+fetch ordering, store, timeout, flush, async reset.
module tb_sram_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        flush_i;
    logic        pipe_stall_i;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [1:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_ce_i      (if_ce_i),
        .if_addr_i    (if_addr_i),
        .if_data_o    (if_data_o),
        .d_ce_i       (d_ce_i),
        .d_we_i       (d_we_i),
        .d_sel_i      (d_sel_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_rdata_o    (d_rdata_o),
        .flush_i      (flush_i),
        .pipe_stall_i (pipe_stall_i),
        .stallreq_o   (stallreq_o),
        .bus_err_o    (bus_err_o),
        .dbg_state_o  (dbg_state_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        if_ce_i = 1'b1; if_addr_i = '0;
        d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'h0; d_addr_i = '0; d_wdata_i = '0;
        flush_i = 1'b0; pipe_stall_i = 1'b0;
        bus.m_ack_i = 1'b0; bus.m_rdata_i = '0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stallreq", 32'(stallreq_o), 32'd0);
        chk("rst_m_ce", 32'(bus.m_ce_o), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'd0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        if_ce_i = 1'b0; d_ce_i = 1'b0;
        rst = 1'b1;

        // fetch only, ack on second access cycle
        cyc(); if_ce_i = 1'b1; if_addr_i = 32'h10; #1;
        chk("f_idle_stall", 32'(stallreq_o), 32'd1);
        chk("f_idle_ce", 32'(bus.m_ce_o), 32'd0);
        cyc(); #1;
        chk("f_acc_ce", 32'(bus.m_ce_o), 32'd1);
        chk("f_acc_addr", bus.m_addr_o, 32'h10);
        chk("f_acc_sel", 32'(bus.m_sel_o), 32'hF);
        chk("f_acc_we", 32'(bus.m_we_o), 32'd0);
        chk("f_acc_state", 32'(dbg_state_o), 32'd2);
        chk("f_acc_stall1", 32'(stallreq_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h3C011234; #1;
        chk("f_ack_ce", 32'(bus.m_ce_o), 32'd1);
        chk("f_acc_stall2", 32'(stallreq_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b0; pipe_stall_i = 1'b1; #1;
        chk("f_done_data", if_data_o, 32'h3C011234);
        chk("f_done_stall", 32'(stallreq_o), 32'd0);
        chk("f_done_ce", 32'(bus.m_ce_o), 32'd0);
        cyc(); pipe_stall_i = 1'b0; #1;
        chk("f_hold_data", if_data_o, 32'h3C011234);
        chk("f_hold_stall", 32'(stallreq_o), 32'd0);

        // simultaneous load and fetch: data first
        cyc(); if_addr_i = 32'h14; d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h100; #1;
        chk("s_consumed_stall", 32'(stallreq_o), 32'd1);
        chk("s_idle_ce", 32'(bus.m_ce_o), 32'd0);
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'hDEADBEEF; #1;
        chk("s_d_ce", 32'(bus.m_ce_o), 32'd1);
        chk("s_d_addr", bus.m_addr_o, 32'h100);
        chk("s_d_state", 32'(dbg_state_o), 32'd1);
        chk("s_d_stall", 32'(stallreq_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b0; #1;
        chk("s_gap_ce", 32'(bus.m_ce_o), 32'd0);
        chk("s_gap_stall", 32'(stallreq_o), 32'd1);
        chk("s_gap_drdata", d_rdata_o, 32'hDEADBEEF);
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h24020005; #1;
        chk("s_i_addr", bus.m_addr_o, 32'h14);
        chk("s_i_state", 32'(dbg_state_o), 32'd2);
        chk("s_i_stall", 32'(stallreq_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b0; #1;
        chk("s_rel_stall", 32'(stallreq_o), 32'd0);
        chk("s_rel_ifdata", if_data_o, 32'h24020005);
        chk("s_rel_drdata", d_rdata_o, 32'hDEADBEEF);

        // store byte, attributes latched at entry
        cyc(); if_ce_i = 1'b0; d_we_i = 1'b1; d_sel_i = 4'b0100; d_addr_i = 32'h200; d_wdata_i = 32'h00AB0000; #1;
        chk("st_idle_stall", 32'(stallreq_o), 32'd1);
        cyc(); #1;
        chk("st_we", 32'(bus.m_we_o), 32'd1);
        chk("st_sel", 32'(bus.m_sel_o), 32'h4);
        chk("st_wdata", bus.m_wdata_o, 32'h00AB0000);
        chk("st_addr", bus.m_addr_o, 32'h200);
        cyc(); d_wdata_i = 32'hFFFFFFFF; d_sel_i = 4'hF; bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h55555555; #1;
        chk("st_wdata_held", bus.m_wdata_o, 32'h00AB0000);
        chk("st_sel_held", 32'(bus.m_sel_o), 32'h4);
        cyc(); bus.m_ack_i = 1'b0; #1;
        chk("st_drdata_zero", d_rdata_o, 32'h0);
        chk("st_done_stall", 32'(stallreq_o), 32'd0);
        chk("st_done_ce", 32'(bus.m_ce_o), 32'd0);

        // fetch timeout with TIMEOUT=8
        cyc(); d_ce_i = 1'b0; d_we_i = 1'b0; if_ce_i = 1'b1; if_addr_i = 32'h40; #1;
        chk("to_idle_stall", 32'(stallreq_o), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            cyc(); #1;
            chk($sformatf("to_wait%0d_err", k), 32'(bus_err_o), 32'd0);
            chk($sformatf("to_wait%0d_ce", k), 32'(bus.m_ce_o), 32'd1);
        end
        cyc(); #1;
        chk("to_c8_err", 32'(bus_err_o), 32'd1);
        chk("to_c8_ce", 32'(bus.m_ce_o), 32'd1);
        cyc(); if_addr_i = 32'h50; #1;
        chk("to_after_err", 32'(bus_err_o), 32'd0);
        chk("to_after_ce", 32'(bus.m_ce_o), 32'd0);
        chk("to_after_ifdata", if_data_o, 32'h0);
        chk("to_after_stall", 32'(stallreq_o), 32'd0);
        chk("to_after_state", 32'(dbg_state_o), 32'd0);

        // flush during fetch, ack three cycles later
        cyc(); #1;
        chk("fl_idle_stall", 32'(stallreq_o), 32'd1);
        cyc(); flush_i = 1'b1; if_addr_i = 32'h80; #1;
        chk("fl_acc_ce", 32'(bus.m_ce_o), 32'd1);
        chk("fl_acc_addr", bus.m_addr_o, 32'h50);
        chk("fl_acc_state", 32'(dbg_state_o), 32'd2);
        cyc(); flush_i = 1'b0; #1;
        chk("fl_disc_state", 32'(dbg_state_o), 32'd3);
        chk("fl_disc_ce", 32'(bus.m_ce_o), 32'd1);
        chk("fl_disc_addr", bus.m_addr_o, 32'h50);
        cyc(); #1;
        chk("fl_disc_ce2", 32'(bus.m_ce_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h11111111; #1;
        chk("fl_disc_ce3", 32'(bus.m_ce_o), 32'd1);
        chk("fl_disc_state3", 32'(dbg_state_o), 32'd3);
        cyc(); bus.m_ack_i = 1'b0; #1;
        chk("fl_idle_ce", 32'(bus.m_ce_o), 32'd0);
        chk("fl_discard_stall", 32'(stallreq_o), 32'd1);
        chk("fl_discard_ifdata", if_data_o, 32'h0);
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h22222222; #1;
        chk("fl_newpc_addr", bus.m_addr_o, 32'h80);
        chk("fl_newpc_ce", 32'(bus.m_ce_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b0; #1;
        chk("fl_newpc_data", if_data_o, 32'h22222222);
        chk("fl_newpc_stall", 32'(stallreq_o), 32'd0);

        // asynchronous reset in the middle of a load
        cyc(); if_ce_i = 1'b0; d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h300; #1;
        chk("rs_idle_stall", 32'(stallreq_o), 32'd1);
        cyc(); #1;
        chk("rs_acc_ce", 32'(bus.m_ce_o), 32'd1);
        chk("rs_acc_addr", bus.m_addr_o, 32'h300);
        rst = 1'b0; #1;
        chk("rs_async_ce", 32'(bus.m_ce_o), 32'd0);
        chk("rs_async_addr", bus.m_addr_o, 32'h0);
        chk("rs_async_state", 32'(dbg_state_o), 32'd0);
        chk("rs_async_ifdata", if_data_o, 32'h0);
        chk("rs_async_stall", 32'(stallreq_o), 32'd0);
        cyc(); rst = 1'b1; #1;
        chk("rs_rel_state", 32'(dbg_state_o), 32'd0);
        chk("rs_rel_ce", 32'(bus.m_ce_o), 32'd0);
        chk("rs_rel_stall", 32'(stallreq_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h33333333; #1;
        chk("rs_restart_ce", 32'(bus.m_ce_o), 32'd1);
        chk("rs_restart_addr", bus.m_addr_o, 32'h300);
        chk("rs_restart_state", 32'(dbg_state_o), 32'd1);
        cyc(); bus.m_ack_i = 1'b0; pipe_stall_i = 1'b1; #1;
        chk("rs_done_drdata", d_rdata_o, 32'h33333333);
        chk("rs_done_stall", 32'(stallreq_o), 32'd0);

        // ack while idle is ignored
        cyc(); bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h44444444; #1;
        chk("ia_ce", 32'(bus.m_ce_o), 32'd0);
        cyc(); bus.m_ack_i = 1'b0; #1;
        chk("ia_drdata", d_rdata_o, 32'h33333333);
        chk("ia_state", 32'(dbg_state_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
